mac_unit: RTL and testbench

- Pipelined unsigned multiply-accumulate block with clock enable and carry-in, used as the arithmetic element of the accelerator datapath.
- Each enabled cycle it multiplies two 16-bit operands and adds the product plus carry-in into a 32-bit running accumulator.
- Includes a synchronous restart-load so a new accumulation can begin without reset.

---
 rtl/mac_pkg.sv | 7 +
 rtl/mac_mult_stage.sv | 33 +++
 rtl/mac_unit.sv | 51 +++++
 tb/tb_mac_unit.sv | 108 ++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared width constants and accumulator type for the MAC datapath.
package mac_pkg;
  localparam int A_W = 16;
  localparam int B_W = 16;
  localparam int P_W = 32;
  typedef logic [P_W-1:0] acc_t;
endpackage

// File: rtl/mac_mult_stage.sv
// mac_mult_stage: registers the full product, carry-in, load flag and a valid bit under CE.
module mac_mult_stage
  import mac_pkg::*;
#(
  parameter int A_WIDTH = A_W,
  parameter int B_WIDTH = B_W,
  parameter int P_WIDTH = P_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               ci,
  input  logic               load,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic [P_WIDTH-1:0] prod_r,
  output logic               ci_r,
  output logic               load_r,
  output logic               v_r
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prod_r <= '0;
      ci_r   <= 1'b0;
      load_r <= 1'b0;
      v_r    <= 1'b0;
    end else if (ce) begin
      prod_r <= P_WIDTH'(a) * P_WIDTH'(b);
      ci_r   <= ci;
      load_r <= load;
      v_r    <= 1'b1;
    end
endmodule

// File: rtl/mac_unit.sv
// mac_unit: pipelined unsigned multiply-accumulate with CE, carry-in and restart-load.
// Define MAC_SAT_EN to add a sticky ovf output and saturating accumulation.
module mac_unit
  import mac_pkg::*;
#(
  parameter int A_WIDTH = A_W,
  parameter int B_WIDTH = B_W,
  parameter int P_WIDTH = P_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               CE,
  input  logic               ci,
  input  logic               load,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic [P_WIDTH-1:0] p
`ifdef MAC_SAT_EN
  ,
  output logic               ovf
`endif
);
`ifdef MAC_SAT_EN
  localparam int SW = P_WIDTH + 1;
`else
  localparam int SW = P_WIDTH;
`endif
  logic [P_WIDTH-1:0] prod_r;
  logic               ci_r, load_r, v_r;
  logic [SW-1:0]      sum;
  mac_mult_stage #(.A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .P_WIDTH(P_WIDTH)) u_mult (
    .clk(clk), .rst_n(rst_n), .ce(CE), .ci(ci), .load(load), .a(a), .b(b),
    .prod_r(prod_r), .ci_r(ci_r), .load_r(load_r), .v_r(v_r)
  );
  // a load sample discards the old accumulator instead of adding to it
  always_comb sum = SW'(load_r ? '0 : p) + SW'(prod_r) + SW'(ci_r);
`ifdef MAC_SAT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p   <= '0;
      ovf <= 1'b0;
    end else if (CE && v_r) begin
      p   <= sum[P_WIDTH] ? '1 : sum[P_WIDTH-1:0];
      ovf <= sum[P_WIDTH] | (ovf & ~load_r);
    end
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) p <= '0;
    else if (CE && v_r) p <= sum;
`endif
endmodule

// File: tb/tb_mac_unit.sv
// tb_mac_unit: directed MAC vectors checked against a behavioural accumulator model and literals.
module tb_mac_unit;
  import mac_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, CE = 1'b0, ci = 1'b0, load = 1'b0;
  logic [15:0] a = '0, b = '0;
  acc_t p;
  logic dut_ovf;
  int total = 0, bad = 0;
  bit run = 1'b0;
`ifdef MAC_SAT_EN
  localparam bit SAT = 1'b1;
  mac_unit dut (.clk(clk), .rst_n(rst_n), .CE(CE), .ci(ci), .load(load), .a(a), .b(b), .p(p), .ovf(dut_ovf));
`else
  localparam bit SAT = 1'b0;
  mac_unit dut (.clk(clk), .rst_n(rst_n), .CE(CE), .ci(ci), .load(load), .a(a), .b(b), .p(p));
  assign dut_ovf = 1'b0;
`endif
  always #5 clk = ~clk;

  // model: each accepted sample becomes a pending contribution applied at the next accepted edge
  longint m_p, pend;
  bit has, pend_ld, m_ovf;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_p <= 0; pend <= 0; has <= 0; pend_ld <= 0; m_ovf <= 0;
    end else if (CE) begin
      if (has) begin
        longint s;
        s = (pend_ld ? 0 : m_p) + pend;
        if (SAT && s > 64'hFFFF_FFFF) begin
          m_p <= 64'hFFFF_FFFF; m_ovf <= 1;
        end else begin
          m_p <= s & 64'hFFFF_FFFF;
          if (pend_ld) m_ovf <= 0;
        end
      end
      pend <= longint'(a) * longint'(b) + longint'(ci);
      pend_ld <= load;
      has <= 1;
    end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (run && rst_n) begin
      chk("model_p", 64'(p), 64'(m_p));
      if (SAT) chk("model_ovf", 64'(dut_ovf), 64'(m_ovf));
    end

  task automatic smp(input bit ce_i, input bit ld, input bit c, input logic [15:0] x, input logic [15:0] y);
    CE = ce_i; load = ld; ci = c; a = x; b = y;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_p", 64'(p), 64'd0);
    rst_n = 1'b1;
    run = 1'b1;
    smp(1, 0, 0, 1, 10);
    smp(1, 0, 0, 2, 10);  chk("seq_10", 64'(p), 64'd10);
    smp(1, 0, 0, 3, 10);  chk("seq_30", 64'(p), 64'd30);
    smp(1, 0, 0, 4, 0);   chk("seq_60", 64'(p), 64'd60);
    smp(1, 1, 1, 1, 10);  chk("seq_60b", 64'(p), 64'd60);
    smp(1, 0, 1, 2, 10);  chk("ci_11", 64'(p), 64'd11);
    smp(1, 0, 1, 3, 10);  chk("ci_32", 64'(p), 64'd32);
    smp(1, 0, 1, 4, 0);   chk("ci_63", 64'(p), 64'd63);
    smp(1, 1, 0, 1, 10);  chk("ci_64", 64'(p), 64'd64);
    smp(1, 0, 0, 2, 10);  chk("st_10", 64'(p), 64'd10);
    smp(1, 0, 0, 3, 10);  chk("st_30", 64'(p), 64'd30);
    for (int i = 0; i < 3; i++) begin
      smp(0, 0, 0, 'x, 'x); chk("stall_hold", 64'(p), 64'd30);
    end
    smp(1, 0, 0, 4, 0);   chk("st_60", 64'(p), 64'd60);
    smp(1, 1, 0, 5, 5);   chk("ld_pre", 64'(p), 64'd60);
    smp(1, 0, 0, 1, 1);   chk("ld_25", 64'(p), 64'd25);
    smp(1, 0, 0, 0, 0);   chk("ld_26", 64'(p), 64'd26);
    #3 rst_n = 1'b0;
    #1 chk("async_rst", 64'(p), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    smp(1, 0, 0, 2, 3);   chk("rst_first", 64'(p), 64'd0);
    smp(1, 0, 0, 0, 0);   chk("rst_6", 64'(p), 64'd6);
    smp(1, 1, 1, 16'hFFFF, 16'hFFFF);
    smp(1, 0, 0, 2, 16'hFFF7); chk("max_prod", 64'(p), 64'hFFFE_0002);
    smp(1, 0, 0, 1, 16'h20);   chk("pre_wrap", 64'(p), 64'hFFFF_FFF0);
    smp(1, 0, 1, 0, 0);
    chk("wrap", 64'(p), SAT ? 64'hFFFF_FFFF : 64'h10);
    if (SAT) chk("ovf_set", 64'(dut_ovf), 64'd1);
    smp(1, 1, 0, 1, 1);
    chk("zero_ci", 64'(p), SAT ? 64'hFFFF_FFFF : 64'h11);
    smp(1, 0, 0, 0, 0);   chk("reload_1", 64'(p), 64'd1);
    if (SAT) chk("ovf_clr", 64'(dut_ovf), 64'd0);
    smp(0, 0, 0, 0, 0);
    smp(0, 0, 0, 0, 0);
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
